regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard in front of the register file's single write port. Accepts write requests from N_REQ sources (ALU, load unit, IDU/SP incrementer) using valid/ready handshakes, and grants one per cycle by round-robin. Drives the regfile write port (writeReg, writeFlag, wrReg, wrData) from a registered output stage. Flags read-after-write hazards on both regfile read ports so the sequencer can stall.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared write-back definitions: write modes, default register count and the
// write/read overlap test that the sequencer also uses for its own stall logic.
package wb_pkg;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_BYTE = 2'b01;
    localparam logic [1:0] WB_PAIR = 2'b10;
    localparam logic [1:0] WB_RSVD = 2'b11;

    localparam int WB_NUM_REGS = 11;
    localparam int WB_RW       = 4;

    // Both sets are contiguous ranges, so an interval intersection test suffices.
    // An even read index covers the pair {idx, idx+1}; an odd one covers {idx}.
    function automatic logic regs_overlap(input logic [WB_RW-1:0] wr_idx,
                                          input logic [1:0]       wr_mode,
                                          input logic [WB_RW-1:0] rd_idx);
        logic [WB_RW:0] one;
        logic [WB_RW:0] w_lo;
        logic [WB_RW:0] w_hi;
        logic [WB_RW:0] r_lo;
        logic [WB_RW:0] r_hi;
        one  = (WB_RW+1)'(1);
        w_lo = {1'b0, wr_idx};
        w_hi = (wr_mode == WB_PAIR) ? w_lo + one : w_lo;
        r_lo = {1'b0, rd_idx};
        r_hi = rd_idx[0] ? r_lo : r_lo + one;
        if (wr_mode != WB_BYTE && wr_mode != WB_PAIR) begin
            return 1'b0;
        end
        return (w_lo <= r_hi) && (r_lo <= w_hi);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves past the winner only when the grant is actually taken (en).
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);

    logic [PW-1:0] ptr;

    always_comb begin
        logic [PW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && any) begin
            ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the regfile's single write port: round-robin
// grant, legality filter, registered write stage and read-after-write hazard flags.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int NUM_REGS = WB_NUM_REGS,
    parameter int RW       = WB_RW,
    parameter int DW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*RW-1:0] req_reg,
    input  logic [N_REQ*2-1:0]  req_mode,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic                wb_hold,
    output logic                writeReg,
    output logic [1:0]          writeFlag,
    output logic [RW-1:0]       wrReg,
    output logic [DW-1:0]       wrData,
    input  logic [RW-1:0]       rdReg1,
    input  logic [RW-1:0]       rdReg2,
    output logic                rd_hazard1,
    output logic                rd_hazard2,
    output logic                err_illegal
);

    localparam int            SW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [RW:0]   REG_LIM = (RW+1)'(NUM_REGS);

    logic [N_REQ-1:0] grant;
    logic [SW-1:0]    sel;
    logic             any_req;
    logic             xfer;

    logic [RW-1:0]    sel_reg;
    logic [1:0]       sel_mode;
    logic [DW-1:0]    sel_data;
    logic [RW:0]      sel_reg_ext;
    logic             sel_illegal;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .en        (~wb_hold),
        .grant     (grant),
        .grant_idx (sel),
        .any       (any_req)
    );

    assign req_ready = wb_hold ? '0 : grant;
    assign xfer      = any_req & ~wb_hold;

    always_comb begin
        sel_reg  = req_reg[sel*RW +: RW];
        sel_mode = req_mode[sel*2 +: 2];
        sel_data = req_data[sel*DW +: DW];
    end

    // A pair write needs an even index and a valid partner register above it.
    always_comb begin
        sel_reg_ext = {1'b0, sel_reg};
        sel_illegal = 1'b0;
        if (sel_reg_ext >= REG_LIM) begin
            sel_illegal = 1'b1;
        end
        if (sel_mode == WB_RSVD) begin
            sel_illegal = 1'b1;
        end
        if (sel_mode == WB_PAIR &&
            (sel_reg[0] || (sel_reg_ext + (RW+1)'(1)) >= REG_LIM)) begin
            sel_illegal = 1'b1;
        end
    end

    // Under hold the stage is frozen as-is; the write strobe only re-arms on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeReg    <= 1'b0;
            writeFlag   <= WB_NONE;
            wrReg       <= '0;
            wrData      <= '0;
            err_illegal <= 1'b0;
        end else if (wb_hold) begin
            err_illegal <= 1'b0;
        end else if (xfer) begin
            err_illegal <= sel_illegal;
            writeReg    <= ~sel_illegal & (sel_mode != WB_NONE);
            if (!sel_illegal) begin
                writeFlag <= sel_mode;
                wrReg     <= sel_reg;
                wrData    <= sel_data;
            end
        end else begin
            writeReg    <= 1'b0;
            err_illegal <= 1'b0;
        end
    end

    assign rd_hazard1 = writeReg & regs_overlap(wrReg, writeFlag, rdReg1);
    assign rd_hazard2 = writeReg & regs_overlap(wrReg, writeFlag, rdReg2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all
// checked against a set-based reference model of the write-back port.
module tb_regfile_wb_arbiter;

    localparam int N_REQ    = 3;
    localparam int NUM_REGS = 11;
    localparam int RW       = 4;
    localparam int DW       = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*RW-1:0] req_reg;
    logic [N_REQ*2-1:0]  req_mode;
    logic [N_REQ*DW-1:0] req_data;
    logic                wb_hold;
    logic                writeReg;
    logic [1:0]          writeFlag;
    logic [RW-1:0]       wrReg;
    logic [DW-1:0]       wrData;
    logic [RW-1:0]       rdReg1;
    logic [RW-1:0]       rdReg2;
    logic                rd_hazard1;
    logic                rd_hazard2;
    logic                err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr;
    bit m_wr;
    int m_flag;
    int m_reg;
    int m_data;
    bit m_err;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .N_REQ(N_REQ), .NUM_REGS(NUM_REGS), .RW(RW), .DW(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_mode    (req_mode),
        .req_data    (req_data),
        .wb_hold     (wb_hold),
        .writeReg    (writeReg),
        .writeFlag   (writeFlag),
        .wrReg       (wrReg),
        .wrData      (wrData),
        .rdReg1      (rdReg1),
        .rdReg2      (rdReg2),
        .rd_hazard1  (rd_hazard1),
        .rd_hazard2  (rd_hazard2),
        .err_illegal (err_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input int r, input int m);
        if (r >= NUM_REGS || m == 3) return 1'b1;
        if (m == 2 && ((r % 2) == 1 || r + 1 >= NUM_REGS)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_hazard(input int rd);
        bit [31:0] wset;
        bit [31:0] rset;
        if (!m_wr) return 1'b0;
        wset = '0;
        rset = '0;
        if (m_flag == 1 || m_flag == 2) wset[m_reg] = 1'b1;
        if (m_flag == 2) wset[m_reg+1] = 1'b1;
        rset[rd] = 1'b1;
        if ((rd % 2) == 0) rset[rd+1] = 1'b1;
        return (wset & rset) != 0;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_wr   = 1'b0;
        m_flag = 0;
        m_reg  = 0;
        m_data = 0;
        m_err  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_writeReg"},  writeReg,    m_wr);
        chk({tag, "_writeFlag"}, writeFlag,   m_flag);
        chk({tag, "_wrReg"},     wrReg,       m_reg);
        chk({tag, "_wrData"},    wrData,      m_data);
        chk({tag, "_err"},       err_illegal, m_err);
    endtask

    // Entered and left at posedge+1: drive, check combinational outputs,
    // advance the model across one edge, check registered outputs.
    task automatic step(input logic [N_REQ-1:0]    v,
                        input logic [N_REQ*RW-1:0] regs,
                        input logic [N_REQ*2-1:0]  modes,
                        input logic [N_REQ*DW-1:0] datas,
                        input logic                hold,
                        input logic [RW-1:0]       rd1,
                        input logic [RW-1:0]       rd2,
                        output int                 gnt);
        logic [N_REQ-1:0] exp_rdy;
        int r;
        int m;
        req_valid = v;
        req_reg   = regs;
        req_mode  = modes;
        req_data  = datas;
        wb_hold   = hold;
        rdReg1    = rd1;
        rdReg2    = rd2;
        #1;
        gnt     = -1;
        exp_rdy = '0;
        if (!hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (gnt < 0 && v[i]) gnt = i;
            end
        end
        if (gnt >= 0) exp_rdy[gnt] = 1'b1;
        chk("ready",   req_ready,  exp_rdy);
        chk("hazard1", rd_hazard1, model_hazard(int'(rd1)));
        chk("hazard2", rd_hazard2, model_hazard(int'(rd2)));
        @(posedge clk);
        #1;
        m_err = 1'b0;
        if (!hold) begin
            if (gnt >= 0) begin
                r     = int'(regs[gnt*RW +: RW]);
                m     = int'(modes[gnt*2 +: 2]);
                m_ptr = (gnt + 1) % N_REQ;
                if (is_illegal(r, m)) begin
                    m_wr  = 1'b0;
                    m_err = 1'b1;
                end else begin
                    m_wr   = (m != 0);
                    m_reg  = r;
                    m_flag = m;
                    m_data = int'(datas[gnt*DW +: DW]);
                end
            end else begin
                m_wr = 1'b0;
            end
        end
        check_outputs("out");
    endtask

    task automatic idle(output int gnt);
        step('0, '0, '0, '0, 1'b0, 4'd1, 4'd1, gnt);
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_reg   = '0;
        req_mode  = '0;
        req_data  = '0;
        wb_hold   = 1'b0;
        rdReg1    = '0;
        rdReg2    = '0;
        rst       = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst_ready", req_ready, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        logic [N_REQ*RW-1:0] rr_regs;
        logic [N_REQ*2-1:0]  rr_modes;
        logic [N_REQ*DW-1:0] rr_datas;

        do_reset();

        // Single byte write from requester 0
        step(3'b001, {4'd0, 4'd0, 4'd3}, {2'b00, 2'b00, 2'b01},
             {16'h0, 16'h0, 16'h00A5}, 1'b0, 4'd1, 4'd1, g);
        chk("t1_grant", g, 0);
        chk("t1_wrReg", wrReg, 4'd3);
        chk("t1_wrData", wrData, 16'h00A5);
        idle(g);
        chk("t1_drop", writeReg, 1'b0);

        // Continuous requests from all three: 0,1,2,0,1,2
        do_reset();
        rr_regs  = {4'd9, 4'd7, 4'd1};
        rr_modes = {2'b01, 2'b01, 2'b01};
        rr_datas = {16'h3333, 16'h2222, 16'h1111};
        for (int k = 0; k < 6; k++) begin
            step(3'b111, rr_regs, rr_modes, rr_datas, 1'b0, 4'd15, 4'd15, g);
            chk("rr_order", g, k % N_REQ);
            chk("rr_strobe", writeReg, 1'b1);
        end
        idle(g);

        // Pair write to 4/5 then read-port snoop during the output cycle
        step(3'b001, {4'd0, 4'd0, 4'd4}, {2'b00, 2'b00, 2'b10},
             {16'h0, 16'h0, 16'h1234}, 1'b0, 4'd1, 4'd1, g);
        step('0, '0, '0, '0, 1'b0, 4'd5, 4'd6, g);
        idle(g);

        // Hold with a write pending and all requesters waiting
        step(3'b010, {4'd0, 4'd8, 4'd0}, {2'b00, 2'b10, 2'b00},
             {16'h0, 16'hBEEF, 16'h0}, 1'b0, 4'd1, 4'd1, g);
        for (int k = 0; k < 3; k++) begin
            step(3'b111, {4'd2, 4'd6, 4'd10}, {2'b01, 2'b01, 2'b01},
                 {16'hC0, 16'hB0, 16'hA0}, 1'b1, 4'd8, 4'd9, g);
            chk("hold_strobe", writeReg, 1'b1);
        end
        step(3'b111, {4'd2, 4'd6, 4'd10}, {2'b01, 2'b01, 2'b01},
             {16'hC0, 16'hB0, 16'hA0}, 1'b0, 4'd8, 4'd9, g);
        chk("hold_resume", g, 2);
        idle(g);

        // Illegal requests: out-of-range index, odd pair, reserved mode
        step(3'b001, {4'd0, 4'd0, 4'd11}, {2'b00, 2'b00, 2'b01},
             {16'h0, 16'h0, 16'h0011}, 1'b0, 4'd1, 4'd1, g);
        chk("ill1_err", err_illegal, 1'b1);
        step(3'b010, {4'd0, 4'd5, 4'd0}, {2'b00, 2'b10, 2'b00},
             {16'h0, 16'h0022, 16'h0}, 1'b0, 4'd1, 4'd1, g);
        chk("ill2_err", err_illegal, 1'b1);
        step(3'b100, {4'd2, 4'd0, 4'd0}, {2'b11, 2'b00, 2'b00},
             {16'h0033, 16'h0, 16'h0}, 1'b0, 4'd1, 4'd1, g);
        chk("ill3_err", err_illegal, 1'b1);
        idle(g);
        chk("ill_pulse", err_illegal, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(N_REQ'($urandom_range(0, 7)),
                 (N_REQ*RW)'($urandom),
                 (N_REQ*2)'($urandom),
                 {16'($urandom), 16'($urandom), 16'($urandom)},
                 ($urandom_range(0, 4) == 0),
                 RW'($urandom), RW'($urandom), g);
        end

        // Asynchronous reset while a write is on the port
        idle(g);
        step(3'b100, {4'd6, 4'd0, 4'd0}, {2'b10, 2'b00, 2'b00},
             {16'h5A5A, 16'h0, 16'h0}, 1'b0, 4'd1, 4'd1, g);
        chk("arst_pre", writeReg, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        step(3'b111, {4'd2, 4'd3, 4'd4}, {2'b01, 2'b01, 2'b01},
             {16'h7, 16'h8, 16'h9}, 1'b0, 4'd1, 4'd1, g);
        chk("arst_first_grant", g, 0);
        idle(g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
